// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - two-requester round-robin arbiter driving a shared 2:1 operand mux
// Registered grant/select, hold limit under contention, registered selected operand with valid strobe.
module mux2_rr_arbiter #(
    parameter int DATAWIDTH = 2,
    parameter int MAXHOLD   = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 req_a,
    input  logic                 req_b,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 grant_a,
    output logic                 grant_b,
    output logic                 sel,
    output logic [DATAWIDTH-1:0] d,
    output logic                 d_valid
);

    localparam int HOLD_W = $clog2(MAXHOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAXHOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic                  ptr_q, ptr_d;
    logic                  sel_q, sel_d;
    logic [DATAWIDTH-1:0]  d_q, d_d;
    logic                  d_valid_q, d_valid_d;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            ptr_q      <= 1'b0;
            sel_q      <= 1'b0;
            d_q        <= '0;
            d_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            d_q        <= d_d;
            d_valid_q  <= d_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        d_d        = d_q;
        d_valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_a && req_b)
                    state_d = ptr_q ? OWN_B : OWN_A;
                else if (req_a)
                    state_d = OWN_A;
                else if (req_b)
                    state_d = OWN_B;
            end
            OWN_A: begin
                if (!req_a)
                    state_d = req_b ? OWN_B : IDLE;
                else if (req_b) begin
                    if (hold_cnt_q == HOLD_LAST)
                        state_d = OWN_B;
                    else
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end else
                    hold_cnt_d = '0;
            end
            OWN_B: begin
                if (!req_b)
                    state_d = req_a ? OWN_A : IDLE;
                else if (req_a) begin
                    if (hold_cnt_q == HOLD_LAST)
                        state_d = OWN_A;
                    else
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end else
                    hold_cnt_d = '0;
            end
            default: state_d = IDLE;
        endcase

        // Any exit from an owner hands priority to the other side.
        if (state_d != state_q) begin
            hold_cnt_d = '0;
            if (state_q != IDLE)
                ptr_d = (state_q == OWN_A);
        end

        case (state_d)
            OWN_A:   sel_d = 1'b0;
            OWN_B:   sel_d = 1'b1;
            default: sel_d = sel_q;
        endcase

        // Capture uses the owner at this edge, so a switching edge still takes the old operand.
        if (state_q == OWN_A && req_a) begin
            d_d       = a;
            d_valid_d = 1'b1;
        end else if (state_q == OWN_B && req_b) begin
            d_d       = b;
            d_valid_d = 1'b1;
        end
    end

    assign grant_a = (state_q == OWN_A);
    assign grant_b = (state_q == OWN_B);
    assign sel     = sel_q;
    assign d       = d_q;
    assign d_valid = d_valid_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb/tb_mux2_rr_arbiter.sv - scoreboard bench for mux2_rr_arbiter
// Two instances share stimulus: MAXHOLD=4 and MAXHOLD=1; each expected entry names which one to check.
module tb_mux2_rr_arbiter;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic [1:0] a = 2'd0;
    logic [1:0] b = 2'd0;
    logic       smp = 1'b0;

    logic       ga4, gb4, sel4, dv4;
    logic [1:0] d4;
    logic       ga1, gb1, sel1, dv1;
    logic [1:0] d1;

    typedef struct {
        logic       which;
        logic [5:0] v;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   vec_id = 0;

    mux2_rr_arbiter #(.DATAWIDTH(2), .MAXHOLD(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
        .grant_a(ga4), .grant_b(gb4), .sel(sel4), .d(d4), .d_valid(dv4)
    );

    mux2_rr_arbiter #(.DATAWIDTH(2), .MAXHOLD(1)) dut1 (
        .Clk(Clk), .Rst(Rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
        .grant_a(ga1), .grant_b(gb1), .sel(sel1), .d(d1), .d_valid(dv1)
    );

    always #5 Clk = ~Clk;

    always begin
        exp_t       e;
        logic [5:0] act;
        @(posedge Clk or posedge smp);
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = e.which ? {ga1, gb1, sel1, d1, dv1} : {ga4, gb4, sel4, d4, dv4};
            n_vec++;
            if (act !== e.v) begin
                n_err++;
                $display("FAIL vec%0d dut%0d: got ga,gb,sel,d,dv=%b_%b_%b_%b_%b want %b_%b_%b_%b_%b",
                         e.id, e.which ? 1 : 4, act[5], act[4], act[3], act[2:1], act[0],
                         e.v[5], e.v[4], e.v[3], e.v[2:1], e.v[0]);
            end
        end
    end

    task automatic push_exp(input logic w, input logic ega, input logic egb,
                            input logic esel, input logic [1:0] ed, input logic edv);
        exp_t e;
        e.which = w;
        e.v     = {ega, egb, esel, ed, edv};
        e.id    = vec_id;
        vec_id++;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic ra, input logic rb, input logic [1:0] av, input logic [1:0] bv,
                        input logic w, input logic ega, input logic egb, input logic esel,
                        input logic [1:0] ed, input logic edv);
        @(negedge Clk);
        req_a = ra;
        req_b = rb;
        a     = av;
        b     = bv;
        push_exp(w, ega, egb, esel, ed, edv);
        @(posedge Clk);
    endtask

    // Asserts reset between edges, checks outputs cleared at once, releases before the next edge.
    task automatic reset_check(input logic w);
        @(negedge Clk);
        #1;
        req_a = 1'b0;
        req_b = 1'b0;
        Rst   = 1'b1;
        #1;
        push_exp(w, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        smp = 1'b1;
        #2;
        smp = 1'b0;
        Rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        reset_check(1'b0);

        // Single requester A: grant after one edge, data valid after two.
        step(1, 0, 2'd2, 2'd1, 0, 1, 0, 0, 2'd0, 0);
        step(1, 0, 2'd2, 2'd1, 0, 1, 0, 0, 2'd2, 1);
        step(0, 0, 2'd2, 2'd1, 0, 0, 0, 0, 2'd2, 0);
        reset_check(1'b0);

        // Contention from IDLE, A hands over to B with no gap, pointer returns to A.
        step(1, 1, 2'd2, 2'd1, 0, 1, 0, 0, 2'd0, 0);
        step(0, 1, 2'd2, 2'd1, 0, 0, 1, 1, 2'd0, 0);
        step(0, 1, 2'd2, 2'd1, 0, 0, 1, 1, 2'd1, 1);
        step(0, 0, 2'd2, 2'd1, 0, 0, 0, 1, 2'd1, 0);
        step(1, 1, 2'd3, 2'd2, 0, 1, 0, 0, 2'd1, 0);
        step(1, 1, 2'd3, 2'd2, 0, 1, 0, 0, 2'd3, 1);
        reset_check(1'b0);

        // Continuous contention with MAXHOLD=4: four cycles each side.
        step(1, 1, 2'd2, 2'd1, 0, 1, 0, 0, 2'd0, 0);
        step(1, 1, 2'd2, 2'd1, 0, 1, 0, 0, 2'd2, 1);
        step(1, 1, 2'd2, 2'd1, 0, 1, 0, 0, 2'd2, 1);
        step(1, 1, 2'd2, 2'd1, 0, 1, 0, 0, 2'd2, 1);
        step(1, 1, 2'd2, 2'd1, 0, 0, 1, 1, 2'd2, 1);
        step(1, 1, 2'd2, 2'd1, 0, 0, 1, 1, 2'd1, 1);
        step(1, 1, 2'd2, 2'd1, 0, 0, 1, 1, 2'd1, 1);
        step(1, 1, 2'd2, 2'd1, 0, 0, 1, 1, 2'd1, 1);
        step(1, 1, 2'd2, 2'd1, 0, 1, 0, 0, 2'd1, 1);
        step(1, 1, 2'd2, 2'd1, 0, 1, 0, 0, 2'd2, 1);
        step(1, 1, 2'd2, 2'd1, 0, 1, 0, 0, 2'd2, 1);
        step(1, 1, 2'd2, 2'd1, 0, 1, 0, 0, 2'd2, 1);
        step(1, 1, 2'd2, 2'd1, 0, 0, 1, 1, 2'd2, 1);
        step(1, 1, 2'd2, 2'd1, 0, 0, 1, 1, 2'd1, 1);

        // Async reset while B owns, then contention restarts with A.
        reset_check(1'b0);
        step(1, 1, 2'd2, 2'd1, 0, 1, 0, 0, 2'd0, 0);

        // B drops for one cycle at hold_cnt=2: A gets four more contention cycles.
        step(1, 1, 2'd2, 2'd1, 0, 1, 0, 0, 2'd2, 1);
        step(1, 1, 2'd2, 2'd1, 0, 1, 0, 0, 2'd2, 1);
        step(1, 0, 2'd2, 2'd1, 0, 1, 0, 0, 2'd2, 1);
        step(1, 1, 2'd2, 2'd1, 0, 1, 0, 0, 2'd2, 1);
        step(1, 1, 2'd2, 2'd1, 0, 1, 0, 0, 2'd2, 1);
        step(1, 1, 2'd2, 2'd1, 0, 1, 0, 0, 2'd2, 1);
        step(1, 1, 2'd2, 2'd1, 0, 0, 1, 1, 2'd2, 1);
        step(0, 0, 2'd2, 2'd1, 0, 0, 0, 1, 2'd2, 0);

        // MAXHOLD=1: ownership and sel alternate every cycle.
        reset_check(1'b1);
        step(1, 1, 2'd2, 2'd1, 1, 1, 0, 0, 2'd0, 0);
        step(1, 1, 2'd2, 2'd1, 1, 0, 1, 1, 2'd2, 1);
        step(1, 1, 2'd2, 2'd1, 1, 1, 0, 0, 2'd1, 1);
        step(1, 1, 2'd2, 2'd1, 1, 0, 1, 1, 2'd2, 1);
        step(1, 1, 2'd2, 2'd1, 1, 1, 0, 0, 2'd1, 1);

        @(negedge Clk);
        req_a = 1'b0;
        req_b = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(negedge Clk);
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
